// File: rtl/branch_resolver_pkg.sv
// Shared types for the branch resolver: the per-stage prediction slot and the
// widths that must agree with the 2-bit predictor table.
package branch_resolver_pkg;

    localparam int PKG_PC_W  = 32;
    localparam int PKG_IDX_W = 2;

    typedef struct packed {
        logic                 valid;
        logic [PKG_IDX_W-1:0] prindex;
        logic                 pred_taken;
        logic [PKG_PC_W-1:0]  pcplus4;
    } pred_slot_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on en, sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (en && (count_q != {W{1'b1}}))
            count_d = count_q + {{(W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) count_q <= '0;
        else       count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/branch_resolver.sv
// Carries IF-stage predictions through ID/EX/MEM, resolves BEQ/BNE in MEM,
// trains the predictor, redirects fetch on mispredict and keeps statistics.
module branch_resolver
    import branch_resolver_pkg::*;
#(
    parameter int PC_W    = PKG_PC_W,
    parameter int IDX_W   = PKG_IDX_W,
    parameter int COUNT_W = 16
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic               pipe_en,
    input  logic               if_valid,
    input  logic [IDX_W-1:0]   if_prindex,
    input  logic               if_pred_taken,
    input  logic [PC_W-1:0]    if_pcplus4,
    input  logic               mem_is_branch,
    input  logic               mem_taken,
    input  logic [PC_W-1:0]    mem_target,
    output logic               mm_update_en,
    output logic [IDX_W-1:0]   mm_prindex,
    output logic               mm_taken,
    output logic               flush,
    output logic [PC_W-1:0]    redirect_pc,
    output logic [COUNT_W-1:0] branch_count,
    output logic [COUNT_W-1:0] mispred_count
);

    pred_slot_t id_q, ex_q, mem_q;
    pred_slot_t id_d, ex_d, mem_d;
    logic       res, mispred;

    always_comb begin
        res     = pipe_en & mem_q.valid & mem_is_branch;
        mispred = res & (mem_q.pred_taken != mem_taken);

        id_d  = id_q;
        ex_d  = ex_q;
        mem_d = mem_q;
        if (pipe_en) begin
            if (mispred) begin
                // Wrong-path squash takes priority; the IF instruction is dropped too.
                id_d.valid  = 1'b0;
                ex_d.valid  = 1'b0;
                mem_d.valid = 1'b0;
            end else begin
                id_d.valid      = if_valid;
                id_d.prindex    = if_prindex;
                id_d.pred_taken = if_pred_taken;
                id_d.pcplus4    = if_pcplus4;
                ex_d            = id_q;
                mem_d           = ex_q;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            id_q  <= '0;
            ex_q  <= '0;
            mem_q <= '0;
        end else begin
            id_q  <= id_d;
            ex_q  <= ex_d;
            mem_q <= mem_d;
        end
    end

    // Update payload is zeroed outside an update so idle outputs stay quiet.
    assign mm_update_en = res;
    assign mm_prindex   = res ? mem_q.prindex : '0;
    assign mm_taken     = res & mem_taken;
    assign flush        = mispred;
    assign redirect_pc  = mispred ? (mem_taken ? mem_target : mem_q.pcplus4) : '0;

    sat_counter #(.W(COUNT_W)) u_branch_cnt (
        .CLK   (CLK),
        .nRST  (nRST),
        .en    (res),
        .count (branch_count)
    );

    sat_counter #(.W(COUNT_W)) u_mispred_cnt (
        .CLK   (CLK),
        .nRST  (nRST),
        .en    (mispred),
        .count (mispred_count)
    );

endmodule
